cmd_dispatcher: RTL and testbench
=================================

# cmd_dispatcher

Parametrised command dispatcher between `uart_rx` and the measurement sub-blocks (test, sampler, sample reader, …). It decodes received command bytes into a one-hot `activate` for one of `NUM_CH` channels and holds it until that channel's `done` handshake completes. It also handles abort and an optional watchdog timeout. It exports an 8-bit status code for the seven-segment display.

## Interface
- `NUM_CH`, default 4: number of channels, 1–16.
- `CMD_BASE`, default 8'h11: command byte selecting channel 0; channel k is selected by `CMD_BASE+k`. Legal only if `CMD_BASE+NUM_CH-1 <= 8'hDF`.
- `ABORT_CMD`, default 8'hFF: aborts the running channel. Must lie outside the channel range.
- `TIMEOUT_CYCLES`, default 50_000_000: watchdog limit, 1 s at 50 MHz. Used only with `CMD_DISPATCH_TIMEOUT_EN`.
- `clk_50mhz`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `rx_data`, in, 8: command byte from `uart_rx`.
- `rx_ready`, in, 1: one-cycle strobe qualifying `rx_data`.
- `done`, in, NUM_CH: per-channel completion flag, level. Synchronous to `clk_50mhz`.
- `activate`, out, NUM_CH: one-hot channel enable, registered.
- `status`, out, 8: display code.
- `busy`, out, 1: high in any state other than IDLE.
- `rejected`, out, 1: one-cycle pulse when a byte is discarded.
- `timed_out`, out, 1: sticky; cleared by the next accepted command or by reset.

## Operation
- Reset values: state IDLE; `activate`=0; `status`=8'h00; `busy`=0; `rejected`=0; `timed_out`=0; watchdog counter 0.
- States:
  - IDLE:
    - `rx_ready` with `rx_data` in [CMD_BASE, CMD_BASE+NUM_CH-1]: set `ch = rx_data-CMD_BASE` (width $clog2(NUM_CH), min 1), set `activate[ch]`, `status=rx_data`, clear `timed_out`, go to RUN.
    - Any other byte, including `ABORT_CMD`: pulse `rejected`, stay IDLE.
  - RUN:
    - `done[ch]`=1: clear `activate`, go to RELEASE.
    - `rx_ready` with `ABORT_CMD`: clear `activate`, go to RELEASE.
    - `rx_ready` with any other byte: pulse `rejected`, keep running.
    - Watchdog reaches `TIMEOUT_CYCLES`: clear `activate`, set `timed_out`, `status=8'hE0|ch`, go to RELEASE.
  - RELEASE:
    - Waits for `done[ch]`=0, then goes to IDLE.
    - `status` becomes 8'h00 on entry to IDLE, unless `timed_out` is set, in which case the E-code is held until the next accepted command.
    - Any `rx_ready` here pulses `rejected`.
- `done` bits of channels other than `ch` are ignored in every state.
- Simultaneous events in RUN:
  - `done[ch]` together with `ABORT_CMD`: treated as done; no reject.
  - `done[ch]` together with a timeout: done wins; no timeout is flagged.
- Asynchronous reset mid-RUN drops `activate` immediately and returns to IDLE. Channels must tolerate `activate` falling without their `done` having been seen.

## Timing
- `rx_ready` accepted at edge n: `activate[ch]`, `busy` and `status` valid after edge n, i.e. registered, 1-cycle latency.
- `done[ch]` high at edge m: `activate` low after edge m.
- Done released at edge r: IDLE after edge r, so `busy` is low from r+1. The earliest next accept is at edge r+1.
- Minimum command-to-command spacing is 3 cycles; the UART byte period (~87 µs at 115200 baud) always exceeds it.
- Watchdog:
  - Counter cleared on entry to RUN and incremented each RUN cycle.
  - Fires on the cycle the count equals `TIMEOUT_CYCLES-1`, so `activate` is high for exactly `TIMEOUT_CYCLES` cycles.
  - Counter width is $clog2(TIMEOUT_CYCLES+1) and it never wraps.
- `rejected` is high for exactly one cycle, on the edge after the offending strobe.

## Configuration
- `CMD_DISPATCH_TIMEOUT_EN` defined: the watchdog counter and the timeout path are compiled in.
- Undefined:
  - No counter is instantiated.
  - RUN exits only on `done[ch]`, ABORT or reset.
  - `timed_out` is tied to 0.
  - `status` never shows an E-code.

## Test plan
- Reset, then `rx_data`=8'h12 (NUM_CH=4): `activate`=4'b0010 and `status`=8'h12 one cycle later. Assert `done[1]`: `activate`=0 next cycle. Drop `done[1]`: `busy`=0 and `status`=8'h00.
- `rx_data`=8'h42 in IDLE, then 8'h13 while channel 2 is running: `rejected` pulses once for each; `activate` stays 0 after the first, and stays 4'b0100 during the second.
- Channel 0 running, `ABORT_CMD` 8'hFF, `done[0]` held 0: `activate` drops next cycle and the block returns to IDLE one cycle later.
- With `CMD_DISPATCH_TIMEOUT_EN` and `TIMEOUT_CYCLES`=10, channel 3, no done: `activate` high for exactly 10 cycles; then `timed_out`=1 and `status`=8'hE3, held until command 8'h11 is accepted.
- Same cycle `done[2]` and ABORT: no `rejected` pulse, no timeout. Separately, assert `reset` low mid-RUN: `activate`=0 asynchronously, before the next edge.
- `done[0]` asserted while channel 1 is running: no effect on state or outputs.

Source files
------------

// File: rtl/cmd_dispatcher.sv
// Command dispatcher: decodes UART command bytes into a one-hot channel activate held until done handshake.
// Optional watchdog timeout compiled in with CMD_DISPATCH_TIMEOUT_EN.
module cmd_dispatcher #(
    parameter int unsigned NUM_CH         = 4,
    parameter logic [7:0]  CMD_BASE       = 8'h11,
    parameter logic [7:0]  ABORT_CMD      = 8'hFF,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic              clk_50mhz,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] activate,
    output logic [7:0]        status,
    output logic              busy,
    output logic              rejected,
    output logic              timed_out
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("cmd_dispatcher: NUM_CH out of range");
    end
    if (int'(CMD_BASE) + NUM_CH - 1 > 32'hDF) begin : g_bad_base
        $error("cmd_dispatcher: command range exceeds 8'hDF");
    end
    if (ABORT_CMD >= CMD_BASE && int'(ABORT_CMD) <= int'(CMD_BASE) + NUM_CH - 1) begin : g_bad_abort
        $error("cmd_dispatcher: ABORT_CMD overlaps channel range");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cmd_dispatcher: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RELEASE
    } state_t;

    state_t            state;
    logic [CH_W-1:0]   ch;
    logic [7:0]        cmd_offs;
    logic              cmd_hit;
    logic [CH_W-1:0]   cmd_ch;
    logic [NUM_CH-1:0] cmd_onehot;
    logic              done_ch;
    logic              abort_hit;

    always_comb begin
        cmd_offs   = rx_data - CMD_BASE;
        cmd_hit    = (rx_data >= CMD_BASE) && (32'(cmd_offs) < NUM_CH);
        cmd_ch     = cmd_offs[CH_W-1:0];
        cmd_onehot = '0;
        cmd_onehot[cmd_ch] = 1'b1;
        done_ch    = done[ch];
        abort_hit  = rx_ready && (rx_data == ABORT_CMD);
    end

    assign busy = (state != IDLE);

`ifdef CMD_DISPATCH_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_fire;

    assign wd_fire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ch        <= '0;
            activate  <= '0;
            status    <= '0;
            rejected  <= 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
            timed_out <= 1'b0;
            wd_cnt    <= '0;
`endif
        end else begin
            rejected <= 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
            // Saturates at TIMEOUT_CYCLES so the counter never wraps.
            if (state == RUN && wd_cnt != WD_W'(TIMEOUT_CYCLES))
                wd_cnt <= wd_cnt + 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (rx_ready) begin
                        if (cmd_hit) begin
                            ch       <= cmd_ch;
                            activate <= cmd_onehot;
                            status   <= rx_data;
                            state    <= RUN;
`ifdef CMD_DISPATCH_TIMEOUT_EN
                            timed_out <= 1'b0;
                            wd_cnt    <= '0;
`endif
                        end else begin
                            rejected <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rx_ready && rx_data != ABORT_CMD)
                        rejected <= 1'b1;
                    // Priority: done, then abort, then watchdog.
                    if (done_ch || abort_hit) begin
                        activate <= '0;
                        state    <= RELEASE;
                    end
`ifdef CMD_DISPATCH_TIMEOUT_EN
                    else if (wd_fire) begin
                        activate  <= '0;
                        timed_out <= 1'b1;
                        status    <= 8'hE0 | 8'(ch);
                        state     <= RELEASE;
                    end
`endif
                end
                RELEASE: begin
                    if (rx_ready)
                        rejected <= 1'b1;
                    if (!done_ch) begin
                        state <= IDLE;
`ifdef CMD_DISPATCH_TIMEOUT_EN
                        if (!timed_out)
                            status <= '0;
`else
                        status <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Scoreboard bench for cmd_dispatcher (NUM_CH=4, TIMEOUT_CYCLES=10); timeout tests follow CMD_DISPATCH_TIMEOUT_EN.
module tb_cmd_dispatcher;

    typedef struct {
        logic [3:0] act;
        logic [7:0] stat;
    } grant_t;

    logic       clk_50mhz = 1'b0;
    logic       reset     = 1'b0;
    logic [7:0] rx_data   = '0;
    logic       rx_ready  = 1'b0;
    logic [3:0] done      = '0;
    logic [3:0] activate;
    logic [7:0] status;
    logic       busy;
    logic       rejected;
    logic       timed_out;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned rej_seen = 0;
    grant_t      exp_q[$];
    logic [3:0]  prev_act = '0;

    cmd_dispatcher #(
        .NUM_CH         (4),
        .CMD_BASE       (8'h11),
        .ABORT_CMD      (8'hFF),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .done      (done),
        .activate  (activate),
        .status    (status),
        .busy      (busy),
        .rejected  (rejected),
        .timed_out (timed_out)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic expect_grant(input logic [3:0] a, input logic [7:0] s);
        grant_t g;
        g.act  = a;
        g.stat = s;
        exp_q.push_back(g);
    endtask

    // Each new grant (activate rising from zero) pops one scoreboard entry.
    always @(negedge clk_50mhz) begin
        if (reset) begin
            if (rejected) rej_seen++;
            if (activate != '0 && prev_act == '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 32'(activate), 32'h0);
                end else begin
                    grant_t g;
                    g = exp_q.pop_front();
                    check("grant_act", 32'(activate), 32'(g.act));
                    check("grant_status", 32'(status), 32'(g.stat));
                end
            end
        end
        prev_act = activate;
    end

    initial begin
        int unsigned n;

        // Reset state
        repeat (3) tick();
        check("rst_activate", 32'(activate), 32'h0);
        check("rst_status", 32'(status), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rejected", 32'(rejected), 32'h0);
        check("rst_timed_out", 32'(timed_out), 32'h0);
        @(negedge clk_50mhz);
        reset = 1'b1;
        tick();

        // Basic command / done handshake on channel 1
        expect_grant(4'b0010, 8'h12);
        send(8'h12);
        check("c1_activate", 32'(activate), 32'h2);
        check("c1_status", 32'(status), 32'h12);
        check("c1_busy", 32'(busy), 32'h1);
        tick();
        done[1] = 1'b1;
        tick();
        check("c1_done_act", 32'(activate), 32'h0);
        check("c1_release_busy", 32'(busy), 32'h1);
        done[1] = 1'b0;
        tick();
        check("c1_idle_busy", 32'(busy), 32'h0);
        check("c1_idle_status", 32'(status), 32'h0);

        // Rejects: bad byte in IDLE, channel byte while running
        send(8'h42);
        check("rej_idle_pulse", 32'(rejected), 32'h1);
        check("rej_idle_act", 32'(activate), 32'h0);
        tick();
        check("rej_idle_oneshot", 32'(rejected), 32'h0);
        expect_grant(4'b0100, 8'h13);
        send(8'h13);
        check("rej_run_noreject", 32'(rejected), 32'h0);
        tick();
        send(8'h13);
        check("rej_run_pulse", 32'(rejected), 32'h1);
        check("rej_run_act", 32'(activate), 32'h4);
        tick();
        check("rej_run_oneshot", 32'(rejected), 32'h0);
        check("rej_run_act2", 32'(activate), 32'h4);
        done[2] = 1'b1;
        tick();
        done[2] = 1'b0;
        tick();
        check("rej_idle_after", 32'(busy), 32'h0);

        // Abort on channel 0 with done low
        expect_grant(4'b0001, 8'h11);
        send(8'h11);
        send(8'hFF);
        check("abort_act", 32'(activate), 32'h0);
        check("abort_busy", 32'(busy), 32'h1);
        check("abort_noreject", 32'(rejected), 32'h0);
        tick();
        check("abort_idle", 32'(busy), 32'h0);
        check("abort_status", 32'(status), 32'h0);

`ifdef CMD_DISPATCH_TIMEOUT_EN
        // Watchdog on channel 3
        expect_grant(4'b1000, 8'h14);
        send(8'h14);
        n = 0;
        while (activate != '0 && n < 50) begin
            n++;
            tick();
        end
        check("wd_active_cycles", n, 10);
        check("wd_timed_out", 32'(timed_out), 32'h1);
        check("wd_status", 32'(status), 32'hE3);
        tick();
        check("wd_idle", 32'(busy), 32'h0);
        repeat (3) tick();
        check("wd_status_held", 32'(status), 32'hE3);
        check("wd_sticky", 32'(timed_out), 32'h1);
        expect_grant(4'b0001, 8'h11);
        send(8'h11);
        check("wd_clear", 32'(timed_out), 32'h0);
        check("wd_new_status", 32'(status), 32'h11);
        done[0] = 1'b1;
        tick();
        done[0] = 1'b0;
        tick();
`else
        // Without the watchdog, RUN persists with no done
        expect_grant(4'b1000, 8'h14);
        send(8'h14);
        repeat (20) tick();
        check("nowd_act", 32'(activate), 32'h8);
        check("nowd_timed_out", 32'(timed_out), 32'h0);
        check("nowd_status", 32'(status), 32'h14);
        send(8'hFF);
        tick();
`endif
        check("pre_sim_idle", 32'(busy), 32'h0);

        // done[ch] and ABORT in the same cycle
        expect_grant(4'b0100, 8'h13);
        send(8'h13);
        tick();
        done[2] = 1'b1;
        send(8'hFF);
        check("sim_noreject", 32'(rejected), 32'h0);
        check("sim_act", 32'(activate), 32'h0);
        check("sim_no_timeout", 32'(timed_out), 32'h0);
        done[2] = 1'b0;
        tick();
        check("sim_idle", 32'(busy), 32'h0);
        check("sim_status", 32'(status), 32'h0);

        // Foreign done bit is ignored
        expect_grant(4'b0010, 8'h12);
        send(8'h12);
        done[0] = 1'b1;
        repeat (3) tick();
        check("foreign_act", 32'(activate), 32'h2);
        check("foreign_busy", 32'(busy), 32'h1);
        check("foreign_status", 32'(status), 32'h12);
        done[0] = 1'b0;

        // Asynchronous reset mid-RUN
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_act", 32'(activate), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_status", 32'(status), 32'h0);
        @(negedge clk_50mhz);
        reset = 1'b1;
        tick();

        check("sb_drained", exp_q.size(), 0);
        check("reject_count", rej_seen, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
